ahb_lite_sram_slave: RTL and testbench
======================================

# ahb_lite_sram_slave

AHB-Lite slave with a small zero-initialised word memory. It sits directly downstream of `ahb_lite_master_read_write_interface` and consumes its HADDR/HWRITE/HSIZE/HWDATA/HTRANS stream. It supports byte, halfword and word accesses with little-endian byte lanes, a parameterised number of wait states, and the two-cycle AHB ERROR response for misaligned or out-of-range accesses. It is the bus target for block-level benches and FPGA bring-up.

## Interface
Parameters:
- `MEM_WORDS`, 16: number of 32-bit words; power of two, 4..256.
- `WAIT_STATES`, 0: HREADYOUT-low cycles inserted in every OKAY data phase, 0..7.

Ports:
- `HCLK` in 1: the single clock; all logic is on the rising edge.
- `HRESET` in 1: synchronous, active-high reset.
- `HSEL` in 1: slave select.
- `HADDR` in 32: byte address.
- `HTRANS` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HWRITE` in 1: 1 for write, 0 for read.
- `HSIZE` in 3: 000 byte, 001 halfword, 010 word; any other value is an error.
- `HWDATA` in 32: write data, valid in the data phase.
- `HREADY` in 1: bus ready; the bench ties it to HREADYOUT.
- `HREADYOUT` out 1: data phase completes when this is 1.
- `HRESP` out 1: 0 OKAY, 1 ERROR.
- `HRDATA` out 32: read data.

## Operation
- **Address phase accept.** A transfer is accepted on a rising edge when `HSEL & HTRANS[1] & HREADY`. HADDR, HWRITE and HSIZE are latched at that edge.
- **IDLE/BUSY and unselected cycles.** HTRANS = IDLE or BUSY, or HSEL = 0, gets a zero-wait OKAY. Nothing is latched and memory is unchanged.
- **Error check at accept.** A transfer is flagged as an error if any of these holds:
  - HSIZE > 010;
  - HSIZE = 001 and HADDR[0] = 1;
  - HSIZE = 010 and HADDR[1:0] ≠ 00;
  - HADDR ≥ 4·MEM_WORDS.
- **Word index.** `HADDR[log2(MEM_WORDS)+1:2]`.
- **State machine:** IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT = 1, HRESP = 0.
    - Accepted error transfer → ERR1.
    - Accepted good transfer with WAIT_STATES > 0 → WAIT, with the counter loaded to WAIT_STATES−1.
    - Accepted good transfer with WAIT_STATES = 0 → stays in IDLE with the data phase marked pending; the next cycle is the completing data phase.
  - WAIT: HREADYOUT = 0, HRESP = 0. The counter decrements each cycle. When it reaches 0, the next cycle is the completing data phase (HREADYOUT = 1) and the FSM returns to IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1 → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1 → IDLE. A new transfer may be accepted in this cycle.
- **Completing data phase.** A good transfer completes in the cycle with HREADYOUT = 1 after its address phase (and after any waits).
  - Write: at the end of that cycle, only the addressed lanes are updated.
    - Byte: lane `HADDR[1:0]` takes `HWDATA[8a+7:8a]`.
    - Halfword: lane pair `HADDR[1]` takes `HWDATA[16h+15:16h]`.
    - Word: all four lanes.
  - Read: HRDATA is the full 32-bit word at the latched index, driven combinationally from the array during that cycle. Sub-word reads return the whole word; the master extracts the lanes.
  - HRDATA = 0 in every other cycle, including ERR1/ERR2.
- **Pipelining.** A new address phase may overlap a completing data phase (HREADY = 1). Back-to-back transfers are therefore sustained at 1 + WAIT_STATES cycles each.
- **Read-after-write.** A read of the same word immediately after a write returns the new data.

## Timing
- **Reset values:** HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM = IDLE, counter = 0, every memory word = 0, no pending phase.
- **Reset mid-operation.** HRESET takes priority over everything. A pending write is discarded and WAIT/ERR states are abandoned. Outputs show reset values on the cycle after the reset edge.
- **Latency:** address-to-data-complete is 1 + WAIT_STATES cycles for OKAY transfers and 2 cycles for ERROR transfers.
- **Wait-state signalling.** HREADYOUT is low only in WAIT and ERR1 and is never low for an IDLE/BUSY transfer.
- **HWDATA sampling.** HWDATA is sampled only at the rising edge that ends the completing data phase.
- **Ignored transfers.** Address phases presented while HREADY = 0 are not accepted; the master must hold them.
- **Error sequence.** HRESP stays 1 for exactly two consecutive cycles per error, low then high HREADYOUT.

## Test plan
1. **Word write/read, WAIT_STATES = 0.** Write 0xFFFFFFFF to 0x4, then read 0x4 → read data phase has HRDATA = 0xFFFFFFFF, HREADYOUT = 1 every cycle, HRESP = 0.
2. **Byte/halfword lanes.** Word-write 0x0 to 0x8, byte-write HWDATA = 0x0000AA00 to 0x9, halfword-write HWDATA = 0xBBBB0000 to 0xA, word-read 0x8 → 0xBBBBAA00.
3. **Wait states, WAIT_STATES = 2.** Back-to-back writes to 0x4, 0x8, 0xC, then reads → HREADYOUT pattern 0,0,1 per transfer; reads return the written data.
4. **Errors.**
   - Halfword at 0x1 → ERR1 (HREADYOUT = 0, HRESP = 1), then ERR2 (HREADYOUT = 1, HRESP = 1); memory unchanged.
   - Word at 0x40 with MEM_WORDS = 16 → same error response.
   - HSIZE = 011 → same error response.
5. **Idle/unselected.** HTRANS = IDLE with HSEL = 1 and HWRITE = 1, and a NONSEQ write with HSEL = 0 → zero-wait OKAY, memory unchanged.
6. **Reset mid-operation.** Assert HRESET during the WAIT state of a write to 0xC (WAIT_STATES = 3) → outputs return to reset values next cycle; a later read of 0xC returns 0.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a zero-initialised word memory with little-endian byte lanes,
// programmable wait states and the two-cycle ERROR response for misaligned/out-of-range accesses.
module ahb_lite_sram_slave #(
   parameter int MEM_WORDS   = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [2:0]    r_cnt;
   logic [2:0]    w_cnt_next;
   logic          r_pend;
   logic          w_pend_next;
   logic          w_load;
   logic [AW-1:0] r_idx;
   logic [1:0]    r_lane;
   logic [1:0]    r_size;
   logic          r_write;
   logic [31:0]   r_mem [MEM_WORDS];

   logic          w_accept;
   logic          w_err;
   logic          w_complete;
   logic [3:0]    w_be;
   logic [31:0]   w_cur;
   logic [31:0]   w_merged;
   logic          w_unused;

   assign w_unused   = &{1'b0, HTRANS[0]};
   assign w_accept   = HSEL & HTRANS[1] & HREADY;
   assign w_err      = (HSIZE > 3'b010)
                     | ((HSIZE == 3'b001) & HADDR[0])
                     | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00))
                     | (HADDR[31:AW+2] != '0);
   // A good transfer's data phase completes in the first IDLE cycle after it was accepted.
   assign w_complete = (r_state == S_IDLE) & r_pend;
   assign w_cur      = r_mem[r_idx];
   assign HRDATA     = (w_complete & ~r_write) ? w_cur : 32'd0;

   always_comb begin
      w_be = 4'b1111;
      case (r_size)
         2'b00:   w_be = 4'b0001 << r_lane;
         2'b01:   w_be = r_lane[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign w_merged[8*gi +: 8] = w_be[gi] ? HWDATA[8*gi +: 8] : w_cur[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_pend_next  = r_pend;
      w_load       = 1'b0;
      HREADYOUT    = 1'b1;
      HRESP        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_pend_next = 1'b0;
         end
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (r_cnt == 3'd0) begin
               w_state_next = S_IDLE;
            end else begin
               w_cnt_next = r_cnt - 3'd1;
            end
         end
         S_ERR1: begin
            HREADYOUT    = 1'b0;
            HRESP        = 1'b1;
            w_state_next = S_ERR2;
         end
         S_ERR2: begin
            HRESP        = 1'b1;
            w_pend_next  = 1'b0;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      // New address phases are only taken in cycles that drive HREADYOUT high.
      if (((r_state == S_IDLE) || (r_state == S_ERR2)) && w_accept) begin
         if (w_err) begin
            w_state_next = S_ERR1;
            w_pend_next  = 1'b0;
         end else begin
            w_load      = 1'b1;
            w_pend_next = 1'b1;
            if (WAIT_STATES > 0) begin
               w_state_next = S_WAIT;
               w_cnt_next   = WS_LOAD;
            end else begin
               w_state_next = S_IDLE;
            end
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_pend  <= 1'b0;
         r_idx   <= '0;
         r_lane  <= 2'b00;
         r_size  <= 2'b00;
         r_write <= 1'b0;
         for (int i = 0; i < MEM_WORDS; i++) begin
            r_mem[i] <= 32'd0;
         end
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_pend  <= w_pend_next;
         if (w_load) begin
            r_idx   <= HADDR[AW+1:2];
            r_lane  <= HADDR[1:0];
            r_size  <= HSIZE[1:0];
            r_write <= HWRITE;
         end
         if (w_complete & r_write) begin
            r_mem[r_idx] <= w_merged;
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: three instances (0, 2 and 3 wait states) driven with directed
// and random pipelined transfers, checked cycle by cycle against a transaction-level memory model.
module tb_ahb_lite_sram_slave;

   typedef struct packed {
      logic        sel;
      logic [1:0]  trans;
      logic        write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   logic        clk;
   logic        hreset    [3];
   logic        hsel      [3];
   logic [31:0] haddr     [3];
   logic [1:0]  htrans    [3];
   logic        hwrite    [3];
   logic [2:0]  hsize     [3];
   logic [31:0] hwdata    [3];
   logic        hreadyout [3];
   logic        hresp     [3];
   logic [31:0] hrdata    [3];

   logic [31:0] mdl [3][16];
   xfer_t       seq [$];
   int          checks = 0;
   int          errors = 0;

   function automatic int ws_of(input int id);
      return (id == 0) ? 0 : (id == 1) ? 2 : 3;
   endfunction

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         ahb_lite_sram_slave #(
            .MEM_WORDS   (16),
            .WAIT_STATES ((gi == 0) ? 0 : (gi == 1) ? 2 : 3)
         ) u_dut (
            .HCLK      (clk),
            .HRESET    (hreset[gi]),
            .HSEL      (hsel[gi]),
            .HADDR     (haddr[gi]),
            .HTRANS    (htrans[gi]),
            .HWRITE    (hwrite[gi]),
            .HSIZE     (hsize[gi]),
            .HWDATA    (hwdata[gi]),
            .HREADY    (hreadyout[gi]),
            .HREADYOUT (hreadyout[gi]),
            .HRESP     (hresp[gi]),
            .HRDATA    (hrdata[gi])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic write,
                                input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata);
      xfer_t x;
      x.sel = sel; x.trans = trans; x.write = write;
      x.addr = addr; x.size = size; x.wdata = wdata;
      return x;
   endfunction

   function automatic bit is_err(input xfer_t x);
      return (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
             (x.size == 3'd2 && x.addr[1:0] != 2'd0) || (x.addr >= 32'd64);
   endfunction

   // Lane update as a byte-by-byte rule: which bytes of the word the access covers.
   task automatic model_write(input int id, input xfer_t x);
      int w;
      bit en;
      w = int'(x.addr) / 4;
      for (int b = 0; b < 4; b++) begin
         if (x.size == 3'd0)      en = (b == int'(x.addr) % 4);
         else if (x.size == 3'd1) en = (b / 2 == (int'(x.addr) % 4) / 2);
         else                     en = 1'b1;
         if (en) mdl[id][w][8*b +: 8] = x.wdata[8*b +: 8];
      end
   endtask

   task automatic drive_idle(input int id);
      hsel[id] = 1'b0; htrans[id] = 2'b00; hwrite[id] = 1'b0;
      haddr[id] = 32'd0; hsize[id] = 3'd0; hwdata[id] = 32'd0;
   endtask

   // Issues the queued transfers back to back on one instance; call and return just after a posedge.
   task automatic run_seq(input int id);
      int n, len, ws;
      xfer_t cur, prv;
      bit acc, er, last;
      logic [31:0] exp_rd;
      n  = seq.size();
      ws = ws_of(id);
      prv = mk(1'b0, 2'b00, 1'b0, 32'd0, 3'd0, 32'd0);
      for (int k = 0; k <= n; k++) begin
         cur = (k < n) ? seq[k] : mk(1'b0, 2'b00, 1'b0, 32'd0, 3'd0, 32'd0);
         if (k > 0) prv = seq[k-1];
         acc = (k > 0) && prv.sel && prv.trans[1];
         er  = acc && is_err(prv);
         len = !acc ? 1 : er ? 2 : ws + 1;
         for (int c = 0; c < len; c++) begin
            last = (c == len - 1);
            hsel[id] = cur.sel; htrans[id] = cur.trans; hwrite[id] = cur.write;
            haddr[id] = cur.addr; hsize[id] = cur.size; hwdata[id] = prv.wdata;
            exp_rd = (acc && !er && !prv.write && last) ? mdl[id][prv.addr[5:2]] : 32'd0;
            @(negedge clk);
            chk($sformatf("i%0d x%0d c%0d hreadyout", id, k, c), {31'd0, hreadyout[id]}, {31'd0, last});
            chk($sformatf("i%0d x%0d c%0d hresp", id, k, c), {31'd0, hresp[id]}, {31'd0, er});
            chk($sformatf("i%0d x%0d c%0d hrdata", id, k, c), hrdata[id], exp_rd);
            @(posedge clk);
            if (acc && !er && prv.write && last) model_write(id, prv);
            #1;
         end
         if (k > 0)
            $display("inst %0d txn %0d sel=%0d trans=%0d wr=%0d addr=%h size=%0d wdata=%h -> %s",
                     id, k - 1, prv.sel, prv.trans, prv.write, prv.addr, prv.size, prv.wdata,
                     !acc ? "not accepted" : er ? "error" : "okay");
      end
      seq.delete();
   endtask

   initial begin
      int sz, a;
      for (int i = 0; i < 3; i++) begin
         hreset[i] = 1'b1;
         drive_idle(i);
         for (int w = 0; w < 16; w++) mdl[i][w] = 32'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) hreset[i] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("i%0d reset hreadyout", i), {31'd0, hreadyout[i]}, 32'd1);
         chk($sformatf("i%0d reset hresp", i), {31'd0, hresp[i]}, 32'd0);
         chk($sformatf("i%0d reset hrdata", i), hrdata[i], 32'd0);
      end
      @(posedge clk);
      #1;

      // Zero wait states: word write/read, lane merging, errors, idle/unselected.
      seq.push_back(mk(1, 2'b10, 1, 32'h4, 3'd2, 32'hFFFF_FFFF));
      seq.push_back(mk(1, 2'b10, 0, 32'h4, 3'd2, 32'h0));
      seq.push_back(mk(1, 2'b10, 1, 32'h8, 3'd2, 32'h0));
      seq.push_back(mk(1, 2'b11, 1, 32'h9, 3'd0, 32'h0000_AA00));
      seq.push_back(mk(1, 2'b11, 1, 32'hA, 3'd1, 32'hBBBB_0000));
      seq.push_back(mk(1, 2'b10, 0, 32'h8, 3'd2, 32'h0));
      seq.push_back(mk(1, 2'b10, 1, 32'h1, 3'd1, 32'h1234_5678));
      seq.push_back(mk(1, 2'b10, 1, 32'h40, 3'd2, 32'h1234_5678));
      seq.push_back(mk(1, 2'b10, 1, 32'h0, 3'd3, 32'h1234_5678));
      seq.push_back(mk(1, 2'b10, 0, 32'h0, 3'd2, 32'h0));
      seq.push_back(mk(1, 2'b00, 1, 32'h4, 3'd2, 32'h5555_5555));
      seq.push_back(mk(0, 2'b10, 1, 32'h4, 3'd2, 32'h6666_6666));
      seq.push_back(mk(1, 2'b01, 1, 32'h4, 3'd2, 32'h7777_7777));
      seq.push_back(mk(1, 2'b10, 0, 32'h4, 3'd2, 32'h0));
      run_seq(0);

      // Two wait states: back-to-back writes then reads, plus an error after a good transfer.
      seq.push_back(mk(1, 2'b10, 1, 32'h4, 3'd2, 32'hA1A1_0001));
      seq.push_back(mk(1, 2'b11, 1, 32'h8, 3'd2, 32'hB2B2_0002));
      seq.push_back(mk(1, 2'b11, 1, 32'hC, 3'd2, 32'hC3C3_0003));
      seq.push_back(mk(1, 2'b10, 0, 32'h4, 3'd2, 32'h0));
      seq.push_back(mk(1, 2'b11, 0, 32'h8, 3'd2, 32'h0));
      seq.push_back(mk(1, 2'b11, 0, 32'hC, 3'd2, 32'h0));
      seq.push_back(mk(1, 2'b10, 1, 32'h6, 3'd2, 32'h0));
      seq.push_back(mk(1, 2'b10, 0, 32'hC, 3'd0, 32'h0));
      run_seq(1);

      // Three wait states: fill 0xC, then reset in the WAIT of a second write.
      seq.push_back(mk(1, 2'b10, 1, 32'hC, 3'd2, 32'h1122_3344));
      seq.push_back(mk(1, 2'b10, 0, 32'hC, 3'd2, 32'h0));
      run_seq(2);
      hsel[2] = 1'b1; htrans[2] = 2'b10; hwrite[2] = 1'b1;
      haddr[2] = 32'hC; hsize[2] = 3'd2;
      @(posedge clk);
      #1;
      drive_idle(2);
      hwdata[2] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("i2 wait hreadyout", {31'd0, hreadyout[2]}, 32'd0);
      hreset[2] = 1'b1;
      @(posedge clk);
      #1;
      hreset[2] = 1'b0;
      for (int w = 0; w < 16; w++) mdl[2][w] = 32'd0;
      @(negedge clk);
      chk("i2 post-reset hreadyout", {31'd0, hreadyout[2]}, 32'd1);
      chk("i2 post-reset hresp", {31'd0, hresp[2]}, 32'd0);
      chk("i2 post-reset hrdata", hrdata[2], 32'd0);
      @(posedge clk);
      #1;
      $display("inst 2 reset asserted during WAIT of write to 0000000c");
      seq.push_back(mk(1, 2'b10, 0, 32'hC, 3'd2, 32'h0));
      run_seq(2);

      // Random pipelined traffic on every instance.
      for (int id = 0; id < 3; id++) begin
         for (int t = 0; t < 40; t++) begin
            sz = $urandom_range(0, 9);
            sz = (sz < 9) ? sz % 3 : 3 + $urandom_range(0, 4);
            a  = $urandom_range(0, 71);
            if ($urandom_range(0, 3) != 0 && sz < 3) a = a & ~((1 << sz) - 1);
            seq.push_back(mk($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
                             1'($urandom_range(0, 1)), 32'(a), 3'(sz), $urandom));
         end
         run_seq(id);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
